// File: rtl/vc_request_generator_pkg.sv
// Shared types and elaboration-time helpers for the VC request generator.
// Imported by the credit counter and the top level.
package vc_request_generator_pkg;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

    // Ceiling log2, used to size counters and VC indices at elaboration time
    function automatic int clog2_f(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vc_request_generator_credit_counter.sv
// Per-VC downstream credit counter: resets to full, saturates at full and at empty.
// Flags an overflow when a credit returns while the counter is already full.
module vc_credit_counter
    import vc_request_generator_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    dec,
    output logic [CREDIT_WIDTH-1:0] count,
    output logic                    overflow
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX  = CREDIT_WIDTH'(BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ZERO = {CREDIT_WIDTH{1'b0}};
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE  = CREDIT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0] count_r;

    // Overflow only when a credit arrives alone on a full counter
    always_comb begin
        overflow = inc & ~dec & (count_r == CREDIT_MAX);
    end

    // Credit register; simultaneous inc and dec cancel out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CREDIT_MAX;
        end else if (inc && !dec) begin
            if (count_r != CREDIT_MAX) begin
                count_r <= count_r + CREDIT_ONE;
            end else begin
                count_r <= count_r;
            end
        end else if (dec && !inc) begin
            if (count_r != CREDIT_ZERO) begin
                count_r <= count_r - CREDIT_ONE;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/vc_request_generator.sv
// Requester side of the one-hot switch arbiter handshake: per-VC credit tracking,
// request generation, grant validation and optional packet-level port locking.
module vc_request_generator
    import vc_request_generator_pkg::*;
#(
    parameter int   VC_NUM       = 4,
    parameter int   BUFFER_DEPTH = 4,
    parameter bit   PACKET_LOCK  = 1'b1,
    localparam int  CREDIT_WIDTH = clog2_f(BUFFER_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [VC_NUM-1:0]                flit_pending,
    input  logic [VC_NUM-1:0]                tail_flit,
    input  logic [VC_NUM-1:0]                credit_in,
    input  logic [VC_NUM-1:0]                grant,
    output logic [VC_NUM-1:0]                request,
    output logic [VC_NUM-1:0]                dequeue,
    output logic [VC_NUM*CREDIT_WIDTH-1:0]   credit_count,
    output logic                             locked,
    output logic                             err
);

    localparam int VC_IDX_W = clog2_f(VC_NUM);

    logic [CREDIT_WIDTH-1:0] credit_s [VC_NUM];
    logic [VC_NUM-1:0]       overflow_s;
    logic [VC_NUM-1:0]       request_s;
    logic [VC_NUM-1:0]       valid_grant_s;
    logic                    multi_grant_s;
    logic                    invalid_grant_s;
    logic                    err_set_s;
    logic                    err_r;
    lock_state_e             lock_state_r;
    logic [VC_IDX_W-1:0]     lock_vc_r;
    logic                    locked_s;

    function automatic logic onehot_or_zero_f(input logic [VC_NUM-1:0] vec);
        return (vec & (vec - {{(VC_NUM-1){1'b0}}, 1'b1})) == {VC_NUM{1'b0}};
    endfunction

    function automatic logic [VC_IDX_W-1:0] vc_index_f(input logic [VC_NUM-1:0] vec);
        logic [VC_IDX_W-1:0] idx;
        idx = {VC_IDX_W{1'b0}};
        for (int i = 0; i < VC_NUM; i++) begin
            if (vec[i]) begin
                idx = VC_IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    genvar gv;
    generate
        for (gv = 0; gv < VC_NUM; gv++) begin : g_credit
            vc_credit_counter #(
                .BUFFER_DEPTH (BUFFER_DEPTH),
                .CREDIT_WIDTH (CREDIT_WIDTH)
            ) u_credit (
                .clk      (clk),
                .reset    (reset),
                .inc      (credit_in[gv]),
                .dec      (valid_grant_s[gv]),
                .count    (credit_s[gv]),
                .overflow (overflow_s[gv])
            );
            assign credit_count[gv*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_s[gv];
        end
    endgenerate

    assign locked_s = (lock_state_r == LOCK_HELD);

    // Requests: pending flit, credit available, and port not held by another VC.
    // Gated by reset so nothing leaks out while reset is asserted.
    always_comb begin
        request_s = {VC_NUM{1'b0}};
        for (int v = 0; v < VC_NUM; v++) begin
            if (reset && flit_pending[v] && (credit_s[v] != {CREDIT_WIDTH{1'b0}}) &&
                (!locked_s || (lock_vc_r == VC_IDX_W'(v)))) begin
                request_s[v] = 1'b1;
            end else begin
                request_s[v] = 1'b0;
            end
        end
    end

    // Grant qualification: multi-bit grants are discarded wholesale
    always_comb begin
        multi_grant_s = ~onehot_or_zero_f(grant);
        if (multi_grant_s) begin
            valid_grant_s = {VC_NUM{1'b0}};
        end else begin
            valid_grant_s = grant & request_s;
        end
        invalid_grant_s = multi_grant_s | (|(grant & ~request_s));
        err_set_s       = invalid_grant_s | (|overflow_s);
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    generate
        if (PACKET_LOCK) begin : g_lock
            lock_state_e         lock_state_s;
            logic [VC_IDX_W-1:0] lock_vc_s;

            // Lock state register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lock_state_r <= LOCK_IDLE;
                    lock_vc_r    <= {VC_IDX_W{1'b0}};
                end else begin
                    lock_state_r <= lock_state_s;
                    lock_vc_r    <= lock_vc_s;
                end
            end

            // Lock on a granted non-tail flit; release on the locked VC's granted tail
            always_comb begin
                lock_state_s = lock_state_r;
                lock_vc_s    = lock_vc_r;
                case (lock_state_r)
                    LOCK_IDLE: begin
                        if ((|valid_grant_s) && ((valid_grant_s & tail_flit) == {VC_NUM{1'b0}})) begin
                            lock_state_s = LOCK_HELD;
                            lock_vc_s    = vc_index_f(valid_grant_s);
                        end else begin
                            lock_state_s = LOCK_IDLE;
                        end
                    end
                    LOCK_HELD: begin
                        if (|(valid_grant_s & tail_flit)) begin
                            lock_state_s = LOCK_IDLE;
                        end else begin
                            lock_state_s = LOCK_HELD;
                        end
                    end
                    default: begin
                        lock_state_s = LOCK_IDLE;
                        lock_vc_s    = {VC_IDX_W{1'b0}};
                    end
                endcase
            end
        end else begin : g_no_lock
            assign lock_state_r = LOCK_IDLE;
            assign lock_vc_r    = {VC_IDX_W{1'b0}};
        end
    endgenerate

    assign request = request_s;
    assign dequeue = valid_grant_s;
    assign locked  = locked_s;
    assign err     = err_r;

endmodule
